// File: rtl/au_add_mw_seq.sv
// ---------------------------------------------------------------------------
// au_add_mw_seq -- multi-word sequential adder/subtractor.
//
// Adds or subtracts two (WIDTH*NWORDS)-bit operands one WIDTH-bit chunk per
// cycle, starting with the least significant chunk. A single AU_add_c
// instance does all the arithmetic. The carry between chunks is held in a
// register. A valid/ready handshake starts each operation, and another
// handshake returns the result.
//
// Ports (top, N = WIDTH*NWORDS):
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous reset, active low
//   in_valid   in   1  operand request
//   in_ready   out  1  operands accepted (high only while idle)
//   a, b       in   N  augend/minuend, addend/subtrahend
//   ci         in   1  carry-in for add (ignored for sub)
//   sub        in   1  1: s = a - b, 0: s = a + b + ci
//   out_valid  out  1  result valid, held until out_ready
//   out_ready  in   1  consumer takes the result
//   s          out  N  sum / difference
//   co         out  1  carry out of bit N-1 (sub: 1 = no borrow)
//   ovf        out  1  signed overflow of the N-bit result
//   busy       out  1  operation in progress or result pending
//
// AU_add_c -- WIDTH-bit parallel-prefix adder with carry in/out.
//   i_a, i_b   in   WIDTH  operands
//   i_ci       in   1      carry-in
//   o_s        out  WIDTH  sum
//   o_co       out  1      carry-out
//   ARCH: 0 = ripple, 1 = Sklansky, 2 = Kogge-Stone.
// ---------------------------------------------------------------------------

module AU_add_c #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co
);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_pp;  // group propagate, bit i down to its span start
  logic [WIDTH-1:0] w_gg;  // group generate; after the tree, carry out of bit i
  logic [WIDTH-1:0] w_c;   // carry into bit i

  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop
    // assignment. Without it, a bit left unwritten on some path becomes a latch.
    w_p  = i_a ^ i_b;
    w_g  = i_a & i_b;
    w_pp = w_p;
    w_gg = w_g;
    w_c  = '0;
    o_s  = '0;
    o_co = 1'b0;

    // Fold the carry-in into bit 0. After this, each group generate is the
    // true carry out of its bit.
    w_gg[0] = w_g[0] | (w_p[0] & i_ci);

    case (ARCH)
      1: begin
        // Sklansky: at level d, every bit that has bit d of its index set
        // combines with the last bit of the lower half-block.
        for (int d = 1; d < WIDTH; d = d * 2) begin
          for (int i = 0; i < WIDTH; i++) begin
            if ((i & d) != 0) begin
              w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[(i & ~(2*d - 1)) + d - 1]);
              w_pp[i] = w_pp[i] & w_pp[(i & ~(2*d - 1)) + d - 1];
            end
          end
        end
      end
      2: begin
        // Kogge-Stone: the loop runs top-down, so each bit still reads the
        // previous level's value at i-d.
        for (int d = 1; d < WIDTH; d = d * 2) begin
          for (int i = WIDTH - 1; i >= d; i--) begin
            w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - d]);
            w_pp[i] = w_pp[i] & w_pp[i - d];
          end
        end
      end
      default: begin
        for (int i = 1; i < WIDTH; i++) begin
          w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - 1]);
        end
      end
    endcase

    w_c[0] = i_ci;
    for (int i = 1; i < WIDTH; i++) begin
      w_c[i] = w_gg[i - 1];
    end
    o_s  = w_p ^ w_c;
    o_co = w_gg[WIDTH - 1];
  end

endmodule


module au_add_mw_seq #(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4,
  parameter int ARCH   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*NWORDS-1:0]  a,
  input  logic [WIDTH*NWORDS-1:0]  b,
  input  logic                     ci,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*NWORDS-1:0]  s,
  output logic                     co,
  output logic                     ovf,
  output logic                     busy
);

  localparam int N  = WIDTH * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;      // already inverted for subtraction
  logic [N-1:0]     r_s;
  logic             r_co;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_chunk;
  logic [WIDTH-1:0] w_b_chunk;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;
  logic             w_last;

  assign w_a_chunk = r_a[r_idx*WIDTH +: WIDTH];
  assign w_b_chunk = r_b[r_idx*WIDTH +: WIDTH];
  assign w_last    = (r_idx == LAST_IDX);

  AU_add_c #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_add (
    .i_a  (w_a_chunk),
    .i_b  (w_b_chunk),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then samples its inputs as they were before the edge, whatever the
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset too, not only the control
      // state. A reset mid-operation therefore leaves no X behind, and the
      // shared adder's inputs stay defined.
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {N{sub}};
            r_carry <= sub | ci;   // subtraction is a + ~b + 1
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_s[r_idx*WIDTH +: WIDTH] <= w_sum;
          r_carry                   <= w_co;
          if (w_last) begin
            r_co    <= w_co;
            // Operands of equal sign whose result has the other sign.
            r_ovf   <= (r_a[N-1] == r_b[N-1]) & (w_sum[WIDTH-1] != r_a[N-1]);
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake flags are decoded straight from the state register. This lets
  // them follow an asynchronous reset without a cycle of delay.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign s         = r_s;
  assign co        = r_co;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_au_add_mw_seq.sv
// ---------------------------------------------------------------------------
// tb_au_add_mw_seq -- self-checking bench for au_add_mw_seq.
// dut0: WIDTH=8, NWORDS=4 (32-bit operands). dut1: WIDTH=8, NWORDS=1.
// Expected results come from an integer-arithmetic model and sit in one
// queue per DUT. A single negedge process compares every valid result cycle.
// Directed runs also pin the model and the DUT to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_au_add_mw_seq;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid0, in_ready0, ci0, sub0, out_valid0, out_ready0;
  logic        co0, ovf0, busy0;
  logic [31:0] a0, b0, s0;

  logic        in_valid1, in_ready1, ci1, sub1, out_valid1, out_ready1;
  logic        co1, ovf1, busy1;
  logic [7:0]  a1, b1, s1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   done0 = 0;
  int   done1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t last0, last1;
  time  t_acc0, t_acc1, t_first0, t_first1;
  logic v0_prev = 1'b0;
  logic v1_prev = 1'b0;

  logic [7:0] bb_a [6] = '{8'h7F, 8'h80, 8'h00, 8'h3C, 8'hFF, 8'h01};
  logic [7:0] bb_b [6] = '{8'h01, 8'h01, 8'h80, 8'hC4, 8'hFF, 8'h02};

  always #5 clk = ~clk;

  au_add_mw_seq #(.WIDTH(8), .NWORDS(4), .ARCH(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .ci(ci0), .sub(sub0), .out_valid(out_valid0),
    .out_ready(out_ready0), .s(s0), .co(co0), .ovf(ovf0), .busy(busy0)
  );

  au_add_mw_seq #(.WIDTH(8), .NWORDS(1), .ARCH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .s(s1), .co(co1), .ovf(ovf1), .busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The result is computed from plain integers. The signed overflow is
  // judged on the exact signed value of a+b+ci or a-b.
  function automatic exp_t model(input longint a, input longint b, input int n,
                                 input logic ci, input logic sub);
    longint mask, half, beff, sum, sa, sb, res;
    exp_t   e;
    mask  = (longint'(1) << n) - 1;
    half  = longint'(1) << (n - 1);
    beff  = sub ? (~b & mask) : b;
    sum   = a + beff + (sub ? longint'(1) : longint'(ci));
    e.s   = 32'(sum & mask);
    e.co  = ((sum >> n) & 1) != 0;
    sa    = (a >= half) ? a - 2*half : a;
    sb    = (b >= half) ? b - 2*half : b;
    res   = sub ? sa - sb : sa + sb + longint'(ci);
    e.ovf = (res >= half) || (res < -half);
    return e;
  endfunction

  // Single compare process: runs on every cycle a result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      v0_prev = 1'b0;
      v1_prev = 1'b0;
    end else begin
      if (out_valid0) begin
        if (!v0_prev) t_first0 = $time;
        check("dut0 in_ready while valid", in_ready0, 0);
        check("dut0 busy while valid", busy0, 1);
        if (q0.size() == 0) begin
          check("dut0 spurious out_valid", out_valid0, 0);
        end else begin
          check("dut0 s", s0, q0[0].s);
          check("dut0 co", co0, q0[0].co);
          check("dut0 ovf", ovf0, q0[0].ovf);
          last0.s = s0; last0.co = co0; last0.ovf = ovf0;
          if (out_ready0) begin
            void'(q0.pop_front());
            done0++;
          end
        end
      end
      if (out_valid1) begin
        if (!v1_prev) t_first1 = $time;
        check("dut1 in_ready while valid", in_ready1, 0);
        if (q1.size() == 0) begin
          check("dut1 spurious out_valid", out_valid1, 0);
        end else begin
          check("dut1 s", s1, q1[0].s);
          check("dut1 co", co1, q1[0].co);
          check("dut1 ovf", ovf1, q1[0].ovf);
          last1.s = {24'b0, s1}; last1.co = co1; last1.ovf = ovf1;
          if (out_ready1) begin
            void'(q1.pop_front());
            done1++;
          end
        end
      end
      v0_prev = out_valid0;
      v1_prev = out_valid1;
    end
  end

  task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
    logic rdy;
    logic acc = 1'b0;
    a0 = a; b0 = b; ci0 = ci; sub0 = sub; in_valid0 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); rdy = in_ready0;
      @(posedge clk);
      if (rdy) begin
        q0.push_back(model(longint'(a), longint'(b), 32, ci, sub));
        t_acc0 = $time;
        acc = 1'b1;
        break;
      end
    end
    #1 in_valid0 = 1'b0;
    if (!acc) check("dut0 accept timeout", acc, 1);
  endtask

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
    logic rdy;
    logic acc = 1'b0;
    a1 = a; b1 = b; ci1 = ci; sub1 = sub; in_valid1 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); rdy = in_ready1;
      @(posedge clk);
      if (rdy) begin
        q1.push_back(model(longint'(a), longint'(b), 8, ci, sub));
        t_acc1 = $time;
        acc = 1'b1;
        break;
      end
    end
    #1 in_valid1 = 1'b0;
    if (!acc) check("dut1 accept timeout", acc, 1);
  endtask

  task automatic wait_done0(input int target);
    for (int k = 0; k < 200 && done0 < target; k++) @(posedge clk);
    #1;
    check("dut0 completion count", done0, target);
  endtask

  task automatic wait_done1(input int target);
    for (int k = 0; k < 200 && done1 < target; k++) @(posedge clk);
    #1;
    check("dut1 completion count", done1, target);
  endtask

  task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                      input logic [31:0] es, input logic eco, input logic eovf);
    exp_t m;
    int   target;
    m = model(longint'(a), longint'(b), 32, ci, sub);
    check("model32 s literal", m.s, es);
    check("model32 co literal", m.co, eco);
    check("model32 ovf literal", m.ovf, eovf);
    target = done0 + 1;
    issue0(a, b, ci, sub);
    wait_done0(target);
    check("dut0 s literal", last0.s, es);
    check("dut0 co literal", last0.co, eco);
    check("dut0 ovf literal", last0.ovf, eovf);
    check("dut0 latency cycles", (t_first0 - t_acc0 - 5) / 10, 4);
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub,
                      input logic [7:0] es, input logic eco, input logic eovf);
    exp_t m;
    int   target;
    m = model(longint'(a), longint'(b), 8, ci, sub);
    check("model8 s literal", m.s, es);
    check("model8 co literal", m.co, eco);
    check("model8 ovf literal", m.ovf, eovf);
    target = done1 + 1;
    issue1(a, b, ci, sub);
    wait_done1(target);
    check("dut1 s literal", last1.s, es);
    check("dut1 co literal", last1.co, eco);
    check("dut1 ovf literal", last1.ovf, eovf);
    check("dut1 latency cycles", (t_first1 - t_acc1 - 5) / 10, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    rst_n = 1'b1;
    in_valid0 = 0; a0 = '0; b0 = '0; ci0 = 0; sub0 = 0; out_ready0 = 1;
    in_valid1 = 0; a1 = '0; b1 = '0; ci1 = 0; sub1 = 0; out_ready1 = 1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready0, 1);
    check("reset out_valid", out_valid0, 0);
    check("reset busy", busy0, 0);
    check("reset s", s0, 0);
    check("reset co", co0, 0);
    check("reset ovf", ovf0, 0);
    check("reset dut1 in_ready", in_ready1, 1);
    check("reset dut1 out_valid", out_valid1, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed 32-bit vectors with hand-computed results.
    run0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run0(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    run0(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run0(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run0(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run0(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run0(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    run0(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
    run0(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0);

    // Back-pressure: the result is held for 10 cycles while in_valid pulses.
    out_ready0 = 1'b0;
    target = done0 + 1;
    issue0(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0);
    for (int k = 0; k < 20 && !out_valid0; k++) @(negedge clk);
    check("hold out_valid reached", out_valid0, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      in_valid0 = k[0];
      a0 = $urandom;
      b0 = $urandom;
      sub0 = k[1];
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    check("hold out_valid dropped", out_valid0, 0);
    check("hold in_ready back", in_ready0, 1);
    check("hold single completion", done0, target);
    repeat (3) @(posedge clk);
    #1;
    check("hold pulses ignored", busy0, 0);

    // Reset during the second RUN cycle aborts the operation.
    issue0(32'h1357_9BDF, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid0, 0);
    check("abort s", s0, 0);
    check("abort co", co0, 0);
    check("abort ovf", ovf0, 0);
    check("abort busy", busy0, 0);
    check("abort in_ready", in_ready0, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-abort in_ready", in_ready0, 1);
    run0(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Single-chunk instance, then back-to-back operations.
    run1(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    target = done1 + 6;
    for (int k = 0; k < 6; k++) begin
      issue1(bb_a[k], bb_b[k], k[1], k[0]);
    end
    wait_done1(target);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
